// File: rtl/fabric_sequencer.sv
// Job sequencer: captures a job, streams depth strided SRAM step addresses to the tiles, drains, then reports done.
// First step one cycle after LOAD; step_addr/step_last hold while step_ready is low and the stall is counted.
module fabric_sequencer #(
    parameter int ADDR_WIDTH   = 32,
    parameter int NUM_TILES    = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_areset,
    input  logic                  fabric_start,
    input  logic [ADDR_WIDTH-1:0] fabric_base_addr,
    input  logic [15:0]           fabric_depth,
    input  logic [7:0]            fabric_stride,
    input  logic [NUM_TILES-1:0]  fabric_tile_mask,
    input  logic [14:0]           fabric_lane_mask,
    input  logic                  step_ready,
    output logic                  step_valid,
    output logic [11:0]           step_addr,
    output logic                  step_last,
    output logic [NUM_TILES-1:0]  step_tile_en,
    output logic [14:0]           step_lane_mask,
    output logic                  acc_clear,
    output logic                  busy,
    output logic                  fabric_done,
    output logic [31:0]           cycle_count,
    output logic [31:0]           utilization_count,
    output logic [31:0]           burst_wait_cycles
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    logic [2:0]  state;
    logic [15:0] depth_q;
    logic [7:0]  stride_q;
    logic [15:0] step_idx;
    logic [3:0]  drain_cnt;
    logic        accept;
    logic        unused_addr_bits;

    // Only the low 12 address bits reach the SRAM; the rest are deliberately dropped.
    assign unused_addr_bits = ^fabric_base_addr;

    assign step_valid  = (state == S_RUN);
    assign step_last   = (state == S_RUN) && (step_idx == depth_q - 16'd1);
    assign acc_clear   = (state == S_LOAD);
    assign busy        = (state == S_LOAD) || (state == S_RUN) || (state == S_DRAIN);
    assign fabric_done = (state == S_DONE);
    assign accept      = step_valid && step_ready;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state             <= S_IDLE;
            depth_q           <= '0;
            stride_q          <= '0;
            step_idx          <= '0;
            drain_cnt         <= '0;
            step_addr         <= '0;
            step_tile_en      <= '0;
            step_lane_mask    <= '0;
            cycle_count       <= '0;
            utilization_count <= '0;
            burst_wait_cycles <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fabric_start) state <= S_LOAD;
                end
                S_LOAD: begin
                    // Job parameters are sampled once here; later input changes are ignored.
                    step_addr         <= fabric_base_addr[11:0];
                    depth_q           <= fabric_depth;
                    stride_q          <= fabric_stride;
                    step_tile_en      <= fabric_tile_mask;
                    step_lane_mask    <= fabric_lane_mask;
                    step_idx          <= '0;
                    drain_cnt         <= '0;
                    cycle_count       <= 32'd1;
                    utilization_count <= '0;
                    burst_wait_cycles <= '0;
                    if ((fabric_depth == 16'd0) || (fabric_tile_mask == '0))
                        state <= S_DRAIN;
                    else
                        state <= S_RUN;
                end
                S_RUN: begin
                    cycle_count <= sat_inc(cycle_count);
                    if (accept) begin
                        utilization_count <= sat_inc(utilization_count);
                        step_addr         <= step_addr + {4'd0, stride_q};
                        step_idx          <= step_idx + 16'd1;
                        if (step_last) begin
                            state     <= S_DRAIN;
                            drain_cnt <= '0;
                        end
                    end else begin
                        burst_wait_cycles <= sat_inc(burst_wait_cycles);
                    end
                end
                S_DRAIN: begin
                    cycle_count <= sat_inc(cycle_count);
                    if (drain_cnt == DRAIN_LAST)
                        state <= S_DONE;
                    else
                        drain_cnt <= drain_cnt + 4'd1;
                end
                S_DONE: begin
                    if (!fabric_start) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fabric_sequencer.sv
// Randomized job bench: expected step addresses and counters come from plain arithmetic over the job parameters.
module tb_fabric_sequencer;

    localparam int DRAIN = 3;
    localparam int NT    = 4;

    logic          clk = 1'b0;
    logic          areset;
    logic          fabric_start;
    logic [31:0]   fabric_base_addr;
    logic [15:0]   fabric_depth;
    logic [7:0]    fabric_stride;
    logic [NT-1:0] fabric_tile_mask;
    logic [14:0]   fabric_lane_mask;
    logic          step_ready;
    logic          step_valid;
    logic [11:0]   step_addr;
    logic          step_last;
    logic [NT-1:0] step_tile_en;
    logic [14:0]   step_lane_mask;
    logic          acc_clear;
    logic          busy;
    logic          fabric_done;
    logic [31:0]   cycle_count;
    logic [31:0]   utilization_count;
    logic [31:0]   burst_wait_cycles;

    int vectors = 0;
    int miscompares = 0;

    fabric_sequencer #(.ADDR_WIDTH(32), .NUM_TILES(NT), .DRAIN_CYCLES(DRAIN)) dut (
        .s_axi_aclk       (clk),
        .s_axi_areset     (areset),
        .fabric_start     (fabric_start),
        .fabric_base_addr (fabric_base_addr),
        .fabric_depth     (fabric_depth),
        .fabric_stride    (fabric_stride),
        .fabric_tile_mask (fabric_tile_mask),
        .fabric_lane_mask (fabric_lane_mask),
        .step_ready       (step_ready),
        .step_valid       (step_valid),
        .step_addr        (step_addr),
        .step_last        (step_last),
        .step_tile_en     (step_tile_en),
        .step_lane_mask   (step_lane_mask),
        .acc_clear        (acc_clear),
        .busy             (busy),
        .fabric_done      (fabric_done),
        .cycle_count      (cycle_count),
        .utilization_count(utilization_count),
        .burst_wait_cycles(burst_wait_cycles)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_valid"}, step_valid, 0);
        check_val({tag, "_addr"}, step_addr, 0);
        check_val({tag, "_last"}, step_last, 0);
        check_val({tag, "_tile"}, step_tile_en, 0);
        check_val({tag, "_lane"}, step_lane_mask, 0);
        check_val({tag, "_clr"}, acc_clear, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, fabric_done, 0);
        check_val({tag, "_cyc"}, cycle_count, 0);
        check_val({tag, "_util"}, utilization_count, 0);
        check_val({tag, "_wait"}, burst_wait_cycles, 0);
    endtask

    // Called at a negedge; the following rising edge is the LOAD entry edge.
    task automatic run_job(input logic [11:0] base, input logic [15:0] depth, input logic [7:0] stride,
                           input logic [NT-1:0] tmask, input logic [14:0] lmask,
                           input int stall_step, input int stall_len, input int rnd_pct, input bit drop_mid);
        int  k = 0;
        int  stalls = 0;
        int  stalled_here = 0;
        int  busy_cyc = 0;
        int  cyc = 0;
        int  exp_busy;
        int  exp_steps;
        bit  runs;
        bit  done_seen = 0;
        bit  rdy;
        runs      = (depth != 0) && (tmask != 0);
        exp_steps = runs ? int'(depth) : 0;
        fabric_base_addr = {20'hA5A5C, base};
        fabric_depth     = depth;
        fabric_stride    = stride;
        fabric_tile_mask = tmask;
        fabric_lane_mask = lmask;
        fabric_start     = 1'b1;
        step_ready       = 1'b0;
        @(negedge clk);
        check_val("load_acc_clear", acc_clear, 1);
        check_val("load_busy", busy, 1);
        check_val("load_valid", step_valid, 0);
        busy_cyc = 1;
        while (!done_seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check_val("clr_cyc", cycle_count, 1);
                check_val("clr_util", utilization_count, 0);
                check_val("clr_wait", burst_wait_cycles, 0);
                check_val("cap_tile", step_tile_en, tmask);
                check_val("cap_lane", step_lane_mask, lmask);
                fabric_base_addr = $urandom;
                fabric_depth     = 16'($urandom);
                fabric_stride    = 8'($urandom);
                fabric_tile_mask = NT'($urandom);
                fabric_lane_mask = 15'($urandom);
            end
            if (fabric_done) begin
                done_seen = 1;
            end else begin
                check_val("busy_during_job", busy, 1);
                busy_cyc++;
                if (step_valid) begin
                    check_val("valid_expected", (runs && k < exp_steps) ? 1 : 0, 1);
                    check_val("step_addr", step_addr, (int'(base) + k * int'(stride)) % 4096);
                    check_val("step_last", step_last, (k == exp_steps - 1) ? 1 : 0);
                    if (k == stall_step && stalled_here < stall_len) begin
                        rdy = 1'b0;
                        stalled_here++;
                    end else begin
                        rdy = ($urandom_range(99) >= rnd_pct);
                    end
                    if (rdy) k++;
                    else stalls++;
                    step_ready = rdy;
                    if (drop_mid) fabric_start = 1'b0;
                end else begin
                    step_ready = 1'($urandom_range(1, 0));
                end
            end
        end
        if (!done_seen) check_val("done_timeout", 0, 1);
        exp_busy = runs ? 1 + exp_steps + stalls + DRAIN : 1 + DRAIN;
        check_val("busy_cycles", busy_cyc, exp_busy);
        check_val("steps_seen", k, exp_steps);
        check_val("cycle_count", cycle_count, exp_busy);
        check_val("utilization", utilization_count, exp_steps);
        check_val("burst_wait", burst_wait_cycles, stalls);
        check_val("done_busy", busy, 0);
        if (fabric_start) begin
            repeat (2) begin
                @(negedge clk);
                check_val("done_held", fabric_done, 1);
            end
            fabric_start = 1'b0;
        end
        @(negedge clk);
        check_val("idle_done", fabric_done, 0);
        check_val("idle_busy", busy, 0);
        check_val("idle_cyc_hold", cycle_count, exp_busy);
        check_val("idle_util_hold", utilization_count, exp_steps);
        step_ready = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        areset           = 1'b1;
        fabric_start     = 1'b0;
        fabric_base_addr = '0;
        fabric_depth     = '0;
        fabric_stride    = '0;
        fabric_tile_mask = '0;
        fabric_lane_mask = '0;
        step_ready       = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        areset = 1'b0;
        @(negedge clk);
        check_val("idle_no_busy", busy, 0);

        run_job(12'h010, 16'd4, 8'd1, 4'hF, 15'h7FFF, -1, 0, 0, 0);   // basic
        run_job(12'h100, 16'd3, 8'd4, 4'h3, 15'h0155, 1, 2, 0, 0);    // backpressure on step 2
        run_job(12'hFFE, 16'd3, 8'd2, 4'h1, 15'h0001, -1, 0, 0, 0);   // wrap
        run_job(12'h020, 16'd0, 8'd1, 4'hF, 15'h0F0F, -1, 0, 0, 0);   // empty depth
        run_job(12'h030, 16'd5, 8'd1, 4'h0, 15'h0F0F, -1, 0, 0, 0);   // empty tile mask
        run_job(12'h040, 16'd6, 8'd0, 4'h8, 15'h4000, -1, 0, 30, 0);  // stride 0
        run_job(12'h050, 16'd5, 8'd3, 4'h5, 15'h1234, -1, 0, 20, 1);  // start drop mid-RUN
        run_job(12'h060, 16'd1, 8'd7, 4'h2, 15'h2222, 0, 3, 0, 0);    // single step

        // Reset mid-RUN with start held through release.
        fabric_base_addr = 32'h0000_0200;
        fabric_depth     = 16'd10;
        fabric_stride    = 8'd3;
        fabric_tile_mask = 4'hF;
        fabric_lane_mask = 15'h00FF;
        fabric_start     = 1'b1;
        step_ready       = 1'b1;
        repeat (5) @(negedge clk);
        check_val("pre_reset_valid", step_valid, 1);
        areset = 1'b1;
        @(negedge clk);
        check_all_zero("midrun_reset");
        areset = 1'b0;
        run_job(12'h300, 16'd4, 8'd5, 4'h6, 15'h0AAA, -1, 0, 25, 0);

        for (int i = 0; i < 25; i++) begin
            run_job(12'($urandom), 16'($urandom_range(12, 0)), 8'($urandom),
                    ($urandom_range(7) == 0) ? 4'h0 : NT'($urandom_range(15, 1)), 15'($urandom),
                    $urandom_range(6) - 1, $urandom_range(3), 30, ($urandom_range(3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
